// File: rtl/rtc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rtc_bus_arbiter
//
// Arbitrates three requesters onto a multiplexed address/data RTC bus and
// runs one bus transaction at a time through ADDR -> LATCH -> DATA -> END
// (TPH cycles each) followed by a single DONE cycle that pulses the ack.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_t, dir_t, dato_t       time-set write request / address / data
//   req_f, dir_f, dato_f       date-set write request / address / data
//   req_l, dir_l               periodic read request / address
//   ack_t, ack_f, ack_l        one-cycle completion pulses
//   dato_leido, valido         last read data and its one-cycle update pulse
//   cs_n, rd_n, wr_n           RTC strobes, active low
//   a_d                        bus phase: 0 address, 1 data
//   bus_out, bus_oe            driven address/data and its tri-state enable
//   bus_in                     RTC data bus readback
//   ocupado                    high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module rtc_bus_arbiter #(
  parameter int TPH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_t,
  input  logic [7:0] dir_t,
  input  logic [7:0] dato_t,
  input  logic       req_f,
  input  logic [7:0] dir_f,
  input  logic [7:0] dato_f,
  input  logic       req_l,
  input  logic [7:0] dir_l,
  output logic       ack_t,
  output logic       ack_f,
  output logic       ack_l,
  output logic [7:0] dato_leido,
  output logic       valido,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       ocupado
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LATCH, S_DATA, S_END, S_DONE
  } state_t;

  localparam logic [1:0] GNT_T = 2'd0;
  localparam logic [1:0] GNT_F = 2'd1;
  localparam logic [1:0] GNT_L = 2'd2;

  localparam logic [3:0] LP_RELOAD = 4'(TPH - 1);

  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic [1:0] r_gnt, w_gnt;
  logic       r_op_rd, w_op_rd;
  logic [7:0] r_addr, w_addr;
  logic [7:0] r_data, w_data;
  logic       w_tmr;

  logic       r_cs_n, r_rd_n, r_wr_n, r_a_d, r_bus_oe;
  logic [7:0] r_bus_out, r_dato_leido;
  logic       r_ack_t, r_ack_f, r_ack_l, r_valido, r_ocupado;

  logic       w_cs_n, w_rd_n, w_wr_n, w_a_d, w_bus_oe;
  logic [7:0] w_bus_out;
  logic       w_ack_t, w_ack_f, w_ack_l, w_valido;

  // Next state, grant capture, and the output values that belong to the
  // next state. Registering the latter keeps every output aligned with the
  // state register instead of trailing it by a cycle.
  always_comb begin
    w_next  = r_state;
    w_gnt   = r_gnt;
    w_op_rd = r_op_rd;
    w_addr  = r_addr;
    w_data  = r_data;
    w_tmr   = (r_cnt == 4'd0);

    case (r_state)
      S_IDLE: begin
        if (req_t) begin
          w_next  = S_ADDR;
          w_gnt   = GNT_T;
          w_op_rd = 1'b0;
          w_addr  = dir_t;
          w_data  = dato_t;
        end else if (req_f) begin
          w_next  = S_ADDR;
          w_gnt   = GNT_F;
          w_op_rd = 1'b0;
          w_addr  = dir_f;
          w_data  = dato_f;
        end else if (req_l) begin
          w_next  = S_ADDR;
          w_gnt   = GNT_L;
          w_op_rd = 1'b1;
          w_addr  = dir_l;
        end
      end
      S_ADDR:  if (w_tmr) w_next = S_LATCH;
      S_LATCH: if (w_tmr) w_next = S_DATA;
      S_DATA:  if (w_tmr) w_next = S_END;
      S_END:   if (w_tmr) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    w_cs_n    = 1'b1;
    w_rd_n    = 1'b1;
    w_wr_n    = 1'b1;
    w_a_d     = 1'b1;
    w_bus_oe  = 1'b0;
    w_bus_out = r_bus_out;
    w_ack_t   = 1'b0;
    w_ack_f   = 1'b0;
    w_ack_l   = 1'b0;
    w_valido  = 1'b0;

    case (w_next)
      S_ADDR: begin
        w_cs_n    = 1'b0;
        w_a_d     = 1'b0;
        w_wr_n    = 1'b0;
        w_bus_oe  = 1'b1;
        w_bus_out = w_addr;
      end
      S_LATCH: begin
        // wr_n rising here is what latches the address inside the RTC.
        w_cs_n   = 1'b0;
        w_a_d    = 1'b0;
        w_bus_oe = 1'b1;
      end
      S_DATA: begin
        w_cs_n = 1'b0;
        if (w_op_rd) begin
          w_rd_n = 1'b0;
        end else begin
          w_wr_n    = 1'b0;
          w_bus_oe  = 1'b1;
          w_bus_out = w_data;
        end
      end
      S_DONE: begin
        w_ack_t  = (w_gnt == GNT_T);
        w_ack_f  = (w_gnt == GNT_F);
        w_ack_l  = (w_gnt == GNT_L);
        w_valido = w_op_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_gnt        <= GNT_T;
      r_op_rd      <= 1'b0;
      r_addr       <= 8'h00;
      r_data       <= 8'h00;
      r_cs_n       <= 1'b1;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_a_d        <= 1'b1;
      r_bus_oe     <= 1'b0;
      r_bus_out    <= 8'h00;
      r_ack_t      <= 1'b0;
      r_ack_f      <= 1'b0;
      r_ack_l      <= 1'b0;
      r_valido     <= 1'b0;
      r_dato_leido <= 8'h00;
      r_ocupado    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_gnt     <= w_gnt;
      r_op_rd   <= w_op_rd;
      r_addr    <= w_addr;
      r_data    <= w_data;
      // Every state entry restarts the phase timer.
      if (w_next != r_state) begin
        r_cnt <= LP_RELOAD;
      end else if (!w_tmr) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_cs_n    <= w_cs_n;
      r_rd_n    <= w_rd_n;
      r_wr_n    <= w_wr_n;
      r_a_d     <= w_a_d;
      r_bus_oe  <= w_bus_oe;
      r_bus_out <= w_bus_out;
      r_ack_t   <= w_ack_t;
      r_ack_f   <= w_ack_f;
      r_ack_l   <= w_ack_l;
      r_valido  <= w_valido;
      r_ocupado <= (w_next != S_IDLE);
      // Read data is taken only at the end of the last DATA cycle, when the
      // RTC has had the full phase to drive the bus.
      if (r_state == S_DATA && r_op_rd && w_tmr) begin
        r_dato_leido <= bus_in;
      end
    end
  end

  assign cs_n       = r_cs_n;
  assign rd_n       = r_rd_n;
  assign wr_n       = r_wr_n;
  assign a_d        = r_a_d;
  assign bus_oe     = r_bus_oe;
  assign bus_out    = r_bus_out;
  assign ack_t      = r_ack_t;
  assign ack_f      = r_ack_f;
  assign ack_l      = r_ack_l;
  assign valido     = r_valido;
  assign dato_leido = r_dato_leido;
  assign ocupado    = r_ocupado;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_arbiter
//
// Drives a TPH=4 arbiter with directed scenarios and then random traffic,
// comparing every cycle against a transaction-level reference model. A
// second TPH=1 instance covers the shortest phase setting.
// ---------------------------------------------------------------------------
module tb_rtc_bus_arbiter;

  localparam int TP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_t, req_f, req_l;
  logic [7:0] dir_t, dato_t, dir_f, dato_f, dir_l, bus_in;
  logic       ack_t, ack_f, ack_l, valido, cs_n, rd_n, wr_n, a_d, bus_oe, ocupado;
  logic [7:0] dato_leido, bus_out;

  logic       u_req_t, u_req_f, u_req_l;
  logic [7:0] u_dir_t, u_dato_t, u_dir_f, u_dato_f, u_dir_l, u_bus_in;
  logic       u_ack_t, u_ack_f, u_ack_l, u_valido, u_cs_n, u_rd_n, u_wr_n, u_a_d;
  logic       u_bus_oe, u_ocupado;
  logic [7:0] u_dato_leido, u_bus_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // transaction-level reference model state
  bit       m_act;
  int       m_k;      // cycle index inside the transaction, 1 .. 4*TP+1
  int       m_id;     // 0 = t, 1 = f, 2 = l
  bit       m_rd;
  logic [7:0] m_addr, m_data, m_bo, m_dl;

  int t_ack_cyc, f_ack_cyc, l_ack_cyc, u_t_ack_cyc, u_l_ack_cyc;
  int t_ack_cnt, rd_low_cnt;

  always #5 clk = ~clk;

  rtc_bus_arbiter #(.TPH(TP)) dut (
    .clk(clk), .reset(reset),
    .req_t(req_t), .dir_t(dir_t), .dato_t(dato_t),
    .req_f(req_f), .dir_f(dir_f), .dato_f(dato_f),
    .req_l(req_l), .dir_l(dir_l),
    .ack_t(ack_t), .ack_f(ack_f), .ack_l(ack_l),
    .dato_leido(dato_leido), .valido(valido),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .ocupado(ocupado)
  );

  rtc_bus_arbiter #(.TPH(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_t(u_req_t), .dir_t(u_dir_t), .dato_t(u_dato_t),
    .req_f(u_req_f), .dir_f(u_dir_f), .dato_f(u_dato_f),
    .req_l(u_req_l), .dir_l(u_dir_l),
    .ack_t(u_ack_t), .ack_f(u_ack_f), .ack_l(u_ack_l),
    .dato_leido(u_dato_leido), .valido(u_valido),
    .cs_n(u_cs_n), .rd_n(u_rd_n), .wr_n(u_wr_n), .a_d(u_a_d),
    .bus_out(u_bus_out), .bus_oe(u_bus_oe), .bus_in(u_bus_in), .ocupado(u_ocupado)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    if (reset) begin
      m_act = 1'b0; m_k = 0; m_bo = 8'h00; m_dl = 8'h00;
    end else if (m_act) begin
      if (m_k == 4*TP+1) begin
        m_act = 1'b0;
      end else begin
        if (m_rd && m_k == 3*TP) m_dl = bus_in;
        m_k++;
        if (!m_rd && m_k == 2*TP+1) m_bo = m_data;
      end
    end else if (req_t || req_f || req_l) begin
      m_act = 1'b1; m_k = 1;
      if (req_t)      begin m_id = 0; m_rd = 1'b0; m_addr = dir_t; m_data = dato_t; end
      else if (req_f) begin m_id = 1; m_rd = 1'b0; m_addr = dir_f; m_data = dato_f; end
      else            begin m_id = 2; m_rd = 1'b1; m_addr = dir_l; end
      m_bo = m_addr;
    end
  endtask

  function automatic logic [25:0] exp_vec();
    logic cs, rd, wr, ad, oe, at, af, al, v, oc;
    int ph;
    cs = 1; rd = 1; wr = 1; ad = 1; oe = 0; at = 0; af = 0; al = 0; v = 0; oc = 0;
    if (m_act) begin
      oc = 1;
      ph = (m_k - 1) / TP;
      case (ph)
        0: begin cs = 0; ad = 0; wr = 0; oe = 1; end
        1: begin cs = 0; ad = 0; oe = 1; end
        2: begin
          cs = 0;
          if (m_rd) rd = 0;
          else begin wr = 0; oe = 1; end
        end
        4: begin at = (m_id == 0); af = (m_id == 1); al = (m_id == 2); v = m_rd; end
        default: ;
      endcase
    end
    return {cs, rd, wr, ad, oe, at, af, al, v, oc, m_bo, m_dl};
  endfunction

  function automatic logic [25:0] dut_vec();
    return {cs_n, rd_n, wr_n, a_d, bus_oe, ack_t, ack_f, ack_l, valido, ocupado, bus_out, dato_leido};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_eq("cycle_vs_model", dut_vec(), exp_vec());
    check_eq("proto_oe_rd", {31'd0, bus_oe & ~rd_n}, 0);
    check_eq("proto_rd_wr", {31'd0, ~rd_n & ~wr_n}, 0);
    check_eq("proto1_oe_rd", {31'd0, u_bus_oe & ~u_rd_n}, 0);
    check_eq("proto1_rd_wr", {31'd0, ~u_rd_n & ~u_wr_n}, 0);
    if (!rd_n && !bus_oe) rd_low_cnt++;
    if (ack_t) begin t_ack_cyc = cyc; t_ack_cnt++; req_t = 1'b0; end
    if (ack_f) begin f_ack_cyc = cyc; req_f = 1'b0; end
    if (ack_l) begin l_ack_cyc = cyc; req_l = 1'b0; end
    if (u_ack_t) begin u_t_ack_cyc = cyc; u_req_t = 1'b0; end
    if (u_ack_l) begin u_l_ack_cyc = cyc; u_req_l = 1'b0; end
  endtask

  task automatic clear_acks();
    t_ack_cyc = -1; f_ack_cyc = -1; l_ack_cyc = -1; u_t_ack_cyc = -1; u_l_ack_cyc = -1;
    t_ack_cnt = 0; rd_low_cnt = 0;
  endtask

  // Bounded wait; an expired bound shows up as a failed comparison.
  task automatic wait_for(input int which, input string tag);
    int n = 0;
    while (n < 120 &&
           ((which == 0 && t_ack_cyc < 0) || (which == 1 && f_ack_cyc < 0) ||
            (which == 2 && l_ack_cyc < 0) || (which == 3 && u_t_ack_cyc < 0) ||
            (which == 4 && u_l_ack_cyc < 0))) begin
      tick();
      n++;
    end
    check_eq({tag, "_timeout"}, (n >= 120) ? 32'd1 : 32'd0, 32'd0);
  endtask

  initial begin
    int cap;
    reset = 1'b1;
    req_t = 0; req_f = 0; req_l = 0;
    dir_t = 0; dato_t = 0; dir_f = 0; dato_f = 0; dir_l = 0; bus_in = 0;
    u_req_t = 0; u_req_f = 0; u_req_l = 0;
    u_dir_t = 0; u_dato_t = 0; u_dir_f = 0; u_dato_f = 0; u_dir_l = 0; u_bus_in = 0;
    m_act = 0; m_k = 0; m_id = 0; m_rd = 0; m_addr = 0; m_data = 0; m_bo = 0; m_dl = 0;
    clear_acks();

    // reset state
    tick(); tick();
    check_eq("reset_outputs", dut_vec(), {5'b11110, 5'b00000, 16'h0000});
    reset = 1'b0;
    tick();

    // time-set write, inputs changed right after the grant
    clear_acks();
    dir_t = 8'h21; dato_t = 8'h45; req_t = 1'b1;
    tick(); cap = cyc;
    dir_t = 8'hFF; dato_t = 8'h00;
    check_eq("wr_addr_bus", bus_out, 8'h21);
    check_eq("wr_addr_ad", a_d, 1'b0);
    repeat (TP) tick();
    check_eq("wr_latch_bus", bus_out, 8'h21);
    check_eq("wr_latch_wrn", wr_n, 1'b1);
    repeat (TP) tick();
    check_eq("wr_data_bus", {a_d, wr_n, bus_out}, {1'b1, 1'b0, 8'h45});
    wait_for(0, "wr_ack");
    check_eq("wr_latency", t_ack_cyc - cap + 1, 4*TP+1);
    tick();
    check_eq("wr_csn_after", cs_n, 1'b1);

    // periodic read
    clear_acks();
    dir_l = 8'h22; bus_in = 8'h37; req_l = 1'b1;
    tick(); cap = cyc;
    wait_for(2, "rd_ack");
    check_eq("rd_latency", l_ack_cyc - cap + 1, 4*TP+1);
    check_eq("rd_valido_with_ack", valido, 1'b1);
    check_eq("rd_data", dato_leido, 8'h37);
    check_eq("rd_strobe_cycles", rd_low_cnt, TP);
    bus_in = 8'h00;
    tick();

    // three simultaneous requests
    clear_acks();
    dir_t = 8'h01; dato_t = 8'h11; dir_f = 8'h02; dato_f = 8'h22; dir_l = 8'h03;
    req_t = 1; req_f = 1; req_l = 1;
    tick(); cap = cyc;
    wait_for(2, "prio_ack_l");
    check_eq("prio_t_latency", t_ack_cyc - cap + 1, 4*TP+1);
    check_eq("prio_f_after_t", f_ack_cyc - t_ack_cyc, 4*TP+2);
    check_eq("prio_l_after_f", l_ack_cyc - f_ack_cyc, 4*TP+2);
    tick();

    // reset during the DATA phase of a write
    clear_acks();
    dir_t = 8'h50; dato_t = 8'h5A; req_t = 1'b1;
    tick();
    repeat (2*TP) tick();
    check_eq("abort_in_data", wr_n, 1'b0);
    reset = 1'b1; req_t = 1'b0;
    tick();
    check_eq("abort_released", {cs_n, wr_n, bus_oe, ocupado}, 4'b1100);
    reset = 1'b0;
    repeat (4*TP+4) tick();
    check_eq("abort_no_ack", t_ack_cnt, 0);
    req_t = 1'b1;
    tick(); cap = cyc;
    wait_for(0, "rereq_ack");
    check_eq("rereq_latency", t_ack_cyc - cap + 1, 4*TP+1);
    tick();

    // write request arriving during a read waits for it
    clear_acks();
    dir_l = 8'h30; req_l = 1'b1;
    tick();
    repeat (3) tick();
    dir_t = 8'h31; dato_t = 8'h77; req_t = 1'b1;
    wait_for(2, "late_rd_ack");
    check_eq("late_no_early_t", t_ack_cyc, -1);
    wait_for(0, "late_wr_ack");
    check_eq("late_wr_next", t_ack_cyc - l_ack_cyc, 4*TP+2);
    tick();

    // random traffic with drops, input churn and occasional reset
    for (int i = 0; i < 2500; i++) begin
      reset = ($urandom_range(399) == 0);
      if (!req_t && $urandom_range(3) == 0) req_t = 1; else if (req_t && $urandom_range(63) == 0) req_t = 0;
      if (!req_f && $urandom_range(3) == 0) req_f = 1; else if (req_f && $urandom_range(63) == 0) req_f = 0;
      if (!req_l && $urandom_range(3) == 0) req_l = 1; else if (req_l && $urandom_range(63) == 0) req_l = 0;
      dir_t = 8'($urandom); dato_t = 8'($urandom);
      dir_f = 8'($urandom); dato_f = 8'($urandom);
      dir_l = 8'($urandom); bus_in = 8'($urandom);
      tick();
    end
    reset = 1'b1; req_t = 0; req_f = 0; req_l = 0;
    tick();
    reset = 1'b0;
    tick();

    // shortest phase setting
    clear_acks();
    u_dir_t = 8'h10; u_dato_t = 8'h99; u_req_t = 1'b1;
    tick(); cap = cyc;
    check_eq("tph1_addr", {u_a_d, u_bus_out}, {1'b0, 8'h10});
    tick(); tick();
    check_eq("tph1_data", {u_a_d, u_wr_n, u_bus_out}, {1'b1, 1'b0, 8'h99});
    wait_for(3, "tph1_wr_ack");
    check_eq("tph1_latency", u_t_ack_cyc - cap + 1, 5);
    tick();
    u_dir_l = 8'h44; u_bus_in = 8'h5A; u_req_l = 1'b1;
    wait_for(4, "tph1_rd_ack");
    check_eq("tph1_rd", {u_valido, u_dato_leido}, {1'b1, 8'h5A});
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
